// File: rtl/mmio_console_tx_if.sv
`default_nettype none
// ============================================================================
// Module   : mmio_console_tx_if
// Purpose  : Processor data-bus view of the console transmitter.
// Revision : 1.0 - initial release
// ============================================================================
interface mmio_console_tx_if;
   logic [31:0] dataadr;
   logic [31:0] writedata;
   logic [1:0]  memwrite;
   logic [31:0] readdata;
   logic        hit;

   modport master (output dataadr, output writedata, output memwrite,
                   input readdata, input hit);
   modport slave  (input dataadr, input writedata, input memwrite,
                   output readdata, output hit);
endinterface
`default_nettype wire

// File: rtl/mmio_console_tx.sv
`default_nettype none
// ============================================================================
// Module   : mmio_console_tx
// Purpose  : Memory-mapped word FIFO feeding an 8N1 serial transmitter.
// Revision : 1.0 - initial release
// ============================================================================
module mmio_console_tx #(
   parameter int          CLKS_PER_BIT = 4,
   parameter int          FIFO_DEPTH   = 4,
   parameter logic [31:0] ADDR_TXDATA  = 32'hFFFF_FFF0,
   parameter logic [31:0] ADDR_STATUS  = 32'hFFFF_FFF4
) (
   input  wire logic        clk,
   input  wire logic        reset,
   mmio_console_tx_if.slave bus,
   output logic             tx,
   output logic             busy
);
   localparam int c_baud_w = $clog2(CLKS_PER_BIT);
   localparam int c_ptr_w  = $clog2(FIFO_DEPTH);
   localparam int c_cnt_w  = c_ptr_w + 1;
   localparam logic [c_baud_w-1:0] c_baud_last = c_baud_w'(CLKS_PER_BIT - 1);
   localparam logic [c_cnt_w-1:0]  c_depth     = c_cnt_w'(FIFO_DEPTH);

   typedef enum logic [1:0] {
      s_idle  = 2'd0,
      s_start = 2'd1,
      s_data  = 2'd2,
      s_stop  = 2'd3
   } state_t;

   logic [31:0]         r_mem [FIFO_DEPTH];
   logic [c_ptr_w-1:0]  r_wptr, r_rptr;
   logic [c_cnt_w-1:0]  r_count;
   logic                r_ovf;

   state_t              r_state, w_state_nxt;
   logic [c_baud_w-1:0] r_baud, w_baud_nxt;
   logic [2:0]          r_bit, w_bit_nxt;
   logic [1:0]          r_idx, w_idx_nxt;
   logic [31:0]         r_word;

   logic w_push_req, w_clr, w_full, w_empty, w_pop, w_push_ok, w_ovf_set;
   logic w_baud_done;
   logic [7:0] w_byte;

   assign w_push_req  = (bus.memwrite == 2'b01) && (bus.dataadr == ADDR_TXDATA);
   assign w_clr       = (bus.memwrite == 2'b01) && (bus.dataadr == ADDR_STATUS);
   assign w_full      = (r_count == c_depth);
   assign w_empty     = (r_count == '0);
   // A full FIFO still accepts a word when the head leaves on the same edge.
   assign w_push_ok   = w_push_req && (!w_full || w_pop);
   assign w_ovf_set   = w_push_req && w_full && !w_pop;
   assign w_baud_done = (r_baud == c_baud_last);
   assign w_byte      = r_word[{r_idx, 3'b000} +: 8];

   assign busy        = !w_empty || (r_state != s_idle);
   assign bus.hit     = (bus.dataadr == ADDR_TXDATA) || (bus.dataadr == ADDR_STATUS);
   assign bus.readdata = (bus.dataadr == ADDR_STATUS) ?
                         {28'b0, r_ovf, w_full, w_empty, busy} : 32'b0;

   always_ff @(posedge clk) begin
      if (w_push_ok) r_mem[r_wptr] <= bus.writedata;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_wptr  <= '0;
         r_rptr  <= '0;
         r_count <= '0;
         r_ovf   <= 1'b0;
      end else begin
         if (w_push_ok) r_wptr <= r_wptr + 1'b1;
         if (w_pop)     r_rptr <= r_rptr + 1'b1;
         case ({w_push_ok, w_pop})
            2'b10:   r_count <= r_count + 1'b1;
            2'b01:   r_count <= r_count - 1'b1;
            default: r_count <= r_count;
         endcase
         if (w_clr)          r_ovf <= 1'b0;
         else if (w_ovf_set) r_ovf <= 1'b1;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state <= s_idle;
         r_baud  <= '0;
         r_bit   <= '0;
         r_idx   <= '0;
         r_word  <= '0;
      end else begin
         r_state <= w_state_nxt;
         r_baud  <= w_baud_nxt;
         r_bit   <= w_bit_nxt;
         r_idx   <= w_idx_nxt;
         if (w_pop) r_word <= r_mem[r_rptr];
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_baud_nxt  = r_baud;
      w_bit_nxt   = r_bit;
      w_idx_nxt   = r_idx;
      w_pop       = 1'b0;
      case (r_state)
         s_idle: begin
            if (!w_empty) begin
               w_pop       = 1'b1;
               w_idx_nxt   = 2'd3;
               w_baud_nxt  = '0;
               w_bit_nxt   = '0;
               w_state_nxt = s_start;
            end
         end
         s_start: begin
            if (w_baud_done) begin
               w_baud_nxt  = '0;
               w_state_nxt = s_data;
            end else begin
               w_baud_nxt = r_baud + 1'b1;
            end
         end
         s_data: begin
            if (w_baud_done) begin
               w_baud_nxt = '0;
               if (r_bit == 3'd7) begin
                  w_bit_nxt   = '0;
                  w_state_nxt = s_stop;
               end else begin
                  w_bit_nxt = r_bit + 1'b1;
               end
            end else begin
               w_baud_nxt = r_baud + 1'b1;
            end
         end
         s_stop: begin
            if (w_baud_done) begin
               w_baud_nxt = '0;
               if (r_idx != 2'd0) begin
                  w_idx_nxt   = r_idx - 1'b1;
                  w_state_nxt = s_start;
               end else begin
                  w_state_nxt = s_idle;
               end
            end else begin
               w_baud_nxt = r_baud + 1'b1;
            end
         end
         default: w_state_nxt = s_idle;
      endcase
   end

   always_comb begin
      tx = 1'b1;
      case (r_state)
         s_start: tx = 1'b0;
         s_data:  tx = w_byte[r_bit];
         default: tx = 1'b1;
      endcase
   end
endmodule
`default_nettype wire

// File: tb/tb_mmio_console_tx.sv
`default_nettype none
// ============================================================================
// Module   : tb_mmio_console_tx
// Purpose  : Self-checking bench: line-waveform queue model plus literal pins.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mmio_console_tx;
   localparam int          CPB   = 4;
   localparam int          DEPTH = 4;
   localparam logic [31:0] A_TX  = 32'hFFFF_FFF0;
   localparam logic [31:0] A_ST  = 32'hFFFF_FFF4;

   logic clk, reset, tx, busy;
   mmio_console_tx_if bus();

   mmio_console_tx #(
      .CLKS_PER_BIT(CPB), .FIFO_DEPTH(DEPTH),
      .ADDR_TXDATA(A_TX), .ADDR_STATUS(A_ST)
   ) dut (
      .clk(clk), .reset(reset), .bus(bus), .tx(tx), .busy(busy)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   int checks = 0;
   int failures = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // Model: queued words plus the exact per-cycle line waveform still to be sent.
   logic [31:0] mq[$];
   bit          ml[$];
   bit          movf;

   task automatic model_clear();
      mq.delete();
      ml.delete();
      movf = 1'b0;
   endtask

   task automatic model_step();
      bit          pop, full_old;
      logic [31:0] w;
      logic [7:0]  bv;
      if (reset) begin
         model_clear();
         return;
      end
      pop      = (ml.size() == 0) && (mq.size() != 0);
      full_old = (mq.size() == DEPTH);
      if (pop) begin
         w = mq.pop_front();
         for (int b = 3; b >= 0; b--) begin
            bv = w[8*b +: 8];
            repeat (CPB) ml.push_back(1'b0);
            for (int i = 0; i < 8; i++) repeat (CPB) ml.push_back(bv[i]);
            repeat (CPB) ml.push_back(1'b1);
         end
      end else if (ml.size() != 0) begin
         void'(ml.pop_front());
      end
      if (bus.memwrite == 2'b01 && bus.dataadr == A_TX) begin
         if (!full_old || pop) mq.push_back(bus.writedata);
         else movf = 1'b1;
      end
      if (bus.memwrite == 2'b01 && bus.dataadr == A_ST) movf = 1'b0;
   endtask

   initial forever begin
      @(posedge clk);
      model_step();
   end

   initial forever begin
      logic        e_tx, e_busy, e_hit;
      logic [31:0] e_rd;
      @(negedge clk);
      if (reset) model_clear();
      e_tx   = (ml.size() == 0) ? 1'b1 : ml[0];
      e_busy = (ml.size() != 0) || (mq.size() != 0);
      e_hit  = (bus.dataadr == A_TX) || (bus.dataadr == A_ST);
      e_rd   = (bus.dataadr == A_ST) ?
               {28'b0, movf, mq.size() == DEPTH, mq.size() == 0, e_busy} : 32'b0;
      check("cyc_tx", {31'b0, tx}, {31'b0, e_tx});
      check("cyc_busy", {31'b0, busy}, {31'b0, e_busy});
      check("cyc_hit", {31'b0, bus.hit}, {31'b0, e_hit});
      check("cyc_readdata", bus.readdata, e_rd);
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic idle_bus();
      bus.dataadr   = 32'h0;
      bus.writedata = 32'h0;
      bus.memwrite  = 2'b00;
   endtask

   task automatic store(input logic [31:0] a, input logic [31:0] d, input logic [1:0] mw);
      bus.dataadr   = a;
      bus.writedata = d;
      bus.memwrite  = mw;
      @(posedge clk);
      #1;
      idle_bus();
   endtask

   task automatic read_status(output logic [31:0] v);
      bus.dataadr  = A_ST;
      bus.memwrite = 2'b00;
      #1;
      v = bus.readdata;
      bus.dataadr = 32'h0;
   endtask

   task automatic wait_idle(input int maxc);
      int n = 0;
      while (busy && n < maxc) begin
         @(posedge clk);
         #1;
         n++;
      end
      check("drain_done", {31'b0, busy}, 32'h0);
   endtask

   logic [31:0] st;
   logic        rec_tx [200];
   logic        rec_busy [200];
   logic [7:0]  exp_b [4];
   logic [7:0]  by;
   int          kb, frm_err, n;

   initial begin
      exp_b = '{8'h41, 8'h42, 8'h43, 8'h44};
      reset = 1'b1;
      idle_bus();
      repeat (3) @(posedge clk);
      #1 reset = 1'b0;

      // Reset state
      check("rst_tx", {31'b0, tx}, 32'h1);
      check("rst_busy", {31'b0, busy}, 32'h0);
      read_status(st);
      check("rst_status", st, 32'h2);
      bus.dataadr = A_TX;
      #1 check("hit_txdata", {31'b0, bus.hit}, 32'h1);
      check("rd_txdata_zero", bus.readdata, 32'h0);
      bus.dataadr = 32'h0;
      repeat (5) @(posedge clk);
      #1 check("no_spont_tx", {31'b0, busy}, 32'h0);

      // Single word: latency, byte order, framing, busy duration
      store(A_TX, 32'h4142_4344, 2'b01);
      for (int k = 0; k < 200; k++) begin
         @(negedge clk);
         rec_tx[k]   = tx;
         rec_busy[k] = busy;
      end
      check("lat_edgeN", {31'b0, rec_tx[0]}, 32'h1);
      check("lat_edgeN1", {31'b0, rec_tx[1]}, 32'h0);
      frm_err = 0;
      for (int j = 0; j < 4; j++) begin
         for (int i = 0; i < 8; i++)
            by[i] = rec_tx[1 + 10*CPB*j + CPB + CPB*i + CPB/2];
         check("byte_decode", {24'b0, by}, {24'b0, exp_b[j]});
         if (rec_tx[1 + 10*CPB*j + CPB/2] !== 1'b0) frm_err++;
         if (rec_tx[1 + 10*CPB*j + 9*CPB + CPB/2] !== 1'b1) frm_err++;
      end
      check("framing_errors", frm_err, 0);
      kb = -1;
      for (int k = 199; k >= 0; k--) if (rec_busy[k]) begin kb = k + 1; break; end
      check("busy_cycles", kb, 161);
      @(posedge clk);
      #1;

      // Six back-to-back stores: word 6 dropped, overflow sticky
      for (int i = 1; i <= 6; i++) store(A_TX, 32'hA000_0000 + i, 2'b01);
      read_status(st);
      check("ovf_status_full", st, 32'hD);
      repeat (170) @(posedge clk);
      #1 read_status(st);
      check("ovf_status", st, 32'h9);
      store(A_ST, 32'h0, 2'b01);
      read_status(st);
      check("ovf_cleared", st, 32'h1);
      wait_idle(1000);
      read_status(st);
      check("drained_status", st, 32'h2);

      // Non-push stores
      store(A_TX, 32'hDEAD_BEEF, 2'b10);
      store(A_TX, 32'hDEAD_BEEF, 2'b00);
      bus.dataadr = 32'h0000_0054;
      #1 check("hit_other", {31'b0, bus.hit}, 32'h0);
      store(32'h0000_0054, 32'hDEAD_BEEF, 2'b01);
      repeat (20) @(posedge clk);
      #1 check("nopush_tx", {31'b0, tx}, 32'h1);
      read_status(st);
      check("nopush_status", st, 32'h2);

      // Reset in the middle of byte 2 data bits
      store(A_TX, 32'h0000_0000, 2'b01);
      repeat (49) @(posedge clk);
      #1 check("mid_data_tx", {31'b0, tx}, 32'h0);
      reset = 1'b1;
      #1 check("async_rst_tx", {31'b0, tx}, 32'h1);
      check("async_rst_busy", {31'b0, busy}, 32'h0);
      repeat (2) @(posedge clk);
      #1 reset = 1'b0;
      read_status(st);
      check("post_rst_status", st, 32'h2);
      repeat (60) @(posedge clk);
      #1 check("post_rst_idle", {31'b0, busy}, 32'h0);

      // Push into a full FIFO on the IDLE-pop edge
      store(A_TX, 32'h1020_3040, 2'b01);
      @(posedge clk);
      #1;
      for (int i = 0; i < 4; i++) store(A_TX, 32'hB000_0000 + i, 2'b01);
      n = 0;
      while (ml.size() != 0 && n < 400) begin
         @(posedge clk);
         #1;
         n++;
      end
      check("idle_gap_found", {31'b0, ml.size() == 0}, 32'h1);
      store(A_TX, 32'hC0FF_EE00, 2'b01);
      read_status(st);
      check("fullpop_status", st, 32'h5);
      wait_idle(1200);

      // Randomized traffic
      for (int it = 0; it < 300; it++) begin
         logic [31:0] a;
         logic [1:0]  mw;
         case ($urandom_range(0, 5))
            0, 1, 2: a = A_TX;
            3:       a = A_ST;
            4:       a = 32'h0000_0054;
            default: a = $urandom;
         endcase
         mw = ($urandom_range(0, 2) != 0) ? 2'b01 : 2'($urandom_range(0, 3));
         store(a, $urandom, mw);
         repeat ($urandom_range(0, 40)) @(posedge clk);
         #1;
      end
      wait_idle(1500);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
`default_nettype wire

// File: doc/mmio_console_tx.md
MMIO_CONSOLE_TX -- requirements
Module: mmio_console_tx

Interface
REQ-001 Parameter CLKS_PER_BIT, default 4: clock cycles per serial bit; legal range is 2 or more.
REQ-002 Parameter FIFO_DEPTH, default 4: number of 32-bit words buffered; must be a power of 2, at least 2.
REQ-003 Parameter ADDR_TXDATA, default 32'hFFFF_FFF0: store address that queues a word.
REQ-004 Parameter ADDR_STATUS, default 32'hFFFF_FFF4: status register address.
REQ-005 clk  input  1  single clock; all state updates on its rising edge.
REQ-006 reset  input  1  asynchronous, active-high reset.
REQ-007 dataadr  input  32  processor data address.
REQ-008 writedata  input  32  processor store data.
REQ-009 memwrite  input  2  store qualifier; 2'b01 = word store; other values = no word store.
REQ-010 readdata  output  32  status read data; combinational.
REQ-011 hit  output  1  combinational; 1 when dataadr equals ADDR_TXDATA or ADDR_STATUS.
REQ-012 tx  output  1  serial line; idle high.
REQ-013 busy  output  1  1 when the FIFO is non-empty or the transmitter is not in IDLE.

Function
REQ-014 A push occurs at a rising edge when memwrite==2'b01 and dataadr==ADDR_TXDATA; writedata is enqueued.
REQ-015 A push while the FIFO is full, with no pop in the same cycle, shall drop the word and set sticky overflow to 1.
REQ-016 A push while full, with a pop in the same edge, shall be accepted; occupancy is unchanged.
REQ-017 A word store (memwrite==2'b01) to ADDR_STATUS shall clear overflow; overflow set and clear in the same edge resolves to clear.
REQ-018 Any memwrite value other than 2'b01, or any other address, shall leave all state unchanged.
REQ-019 readdata shall be {28'b0, overflow, full, empty, busy} when dataadr==ADDR_STATUS, else 32'b0.
REQ-020 Transmitter FSM states: IDLE, START, DATA, STOP.
REQ-021 IDLE with FIFO non-empty: at the next edge, pop the head word into the shift holding register, set byte index to 3, enter START.
REQ-022 START drives tx=0 for CLKS_PER_BIT cycles, then enters DATA.
REQ-023 DATA drives byte[index] LSB first, each bit for CLKS_PER_BIT cycles; after 8 bits it enters STOP.
REQ-024 STOP drives tx=1 for CLKS_PER_BIT cycles.
REQ-025 Leaving STOP: if index>0, decrement index and enter START; if index==0, enter IDLE.
REQ-026 Byte order is bytes 3,2,1,0, i.e. writedata[31:24] first.
REQ-027 One word occupies 40*CLKS_PER_BIT cycles on tx, plus a single IDLE cycle before the next pop.
REQ-028 Latency: for a push at edge N into an empty FIFO with FSM in IDLE, tx falls after edge N+1.
REQ-029 The bit counter and baud counter shall be wide enough for CLKS_PER_BIT-1 and 7; the word pointers shall wrap modulo FIFO_DEPTH.
REQ-030 Stores arriving during transmission shall not disturb the word in flight.

Reset
REQ-031 While reset is asserted: tx=1, busy=0, FSM=IDLE, FIFO empty (pointers and count zero), overflow=0, all counters zero.
REQ-032 Reset asserted mid-frame shall force tx=1 immediately, with no clock edge required, and discard the word in flight and all queued words.
REQ-033 After reset deassertion, no transmission shall begin until a push occurs.

Verification (CLKS_PER_BIT=4, FIFO_DEPTH=4)
REQ-034 Store 32'h4142_4344 to 32'hFFFF_FFF0 with memwrite=2'b01 -> tx falls one cycle after the push edge; bytes 8'h41, 8'h42, 8'h43, 8'h44 are decoded with start=0 and stop=1; busy deasserts after 161 cycles.
REQ-035 Six consecutive word stores to ADDR_TXDATA -> words 1 to 5 are transmitted in order; word 6 is dropped; status read returns 32'h0000_0009 (overflow, busy).
REQ-036 Store to ADDR_STATUS after the overflow in REQ-035 -> overflow=0 in subsequent status reads; the queued words are unaffected.
REQ-037 Stores with memwrite=2'b10 or 2'b00 to ADDR_TXDATA, and with memwrite=2'b01 to 32'h0000_0054 -> no push; tx stays 1; status reads 32'h0000_0002; hit=0 for 32'h0000_0054.
REQ-038 Assert reset during the DATA state of byte 2 -> tx=1 within the same cycle; after release, busy=0 and status reads 32'h0000_0002.
REQ-039 Push into a full FIFO on the same edge as an IDLE pop -> word accepted; overflow remains 0; all words are transmitted in order.
